// File: rtl/bfp_renorm.sv
// Block-floating-point renormaliser: 4 lanes sharing one exponent become per-lane normalised values.
// Optional underflow counter port enabled by defining BFP_UFLOW_CNT_EN.
module bfp_renorm #(
  parameter int expWidth = 4,
  parameter int manWidth = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [expWidth-1:0]     in_max_exp,
  input  logic [4*manWidth-1:0]   in_man,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*expWidth-1:0]   out_exp,
  output logic [4*manWidth-1:0]   out_man,
  output logic [3:0]              out_zero,
  output logic [3:0]              out_uflow
`ifdef BFP_UFLOW_CNT_EN
  ,
  output logic [15:0]             uflow_cnt
`endif
);

  localparam int LANES = 4;
  localparam int LZC_W = $clog2(manWidth + 1);
  localparam int EW1   = expWidth + 1;

  function automatic logic [LZC_W-1:0] lzc_f(input logic [manWidth-1:0] m);
    logic [LZC_W-1:0] n;
    n = LZC_W'(manWidth);
    for (int i = 0; i < manWidth; i++)
      if (m[i]) n = LZC_W'(manWidth - 1 - i);
    return n;
  endfunction

  logic                        vld_p1;
  logic [expWidth-1:0]         exp_p1;
  logic [LANES*manWidth-1:0]   man_p1;
  logic [LANES*LZC_W-1:0]      lzc_p1;
  logic                        s1_adv;
  logic                        s2_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !vld_p1 || s2_adv;
  assign in_ready = rst_n && s1_adv;

  // Stage 1: capture the beat and the per-lane leading-zero counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vld_p1 <= 1'b0;
    else if (s1_adv)
      vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      exp_p1 <= in_max_exp;
      man_p1 <= in_man;
      for (int i = 0; i < LANES; i++)
        lzc_p1[i*LZC_W +: LZC_W] <= lzc_f(in_man[i*manWidth +: manWidth]);
    end
  end

  logic [LANES*expWidth-1:0] exp_nx;
  logic [LANES*manWidth-1:0] man_nx;
  logic [LANES-1:0]          zero_nx;
  logic [LANES-1:0]          uflow_nx;
  logic [manWidth-1:0]       lane_man;
  logic [LZC_W-1:0]          lane_lzc;
  logic signed [expWidth:0]  diff;

  // Zero takes priority over flush; a non-positive difference means the lane underflows
  always_comb begin
    exp_nx   = '0;
    man_nx   = '0;
    zero_nx  = '0;
    uflow_nx = '0;
    lane_man = '0;
    lane_lzc = '0;
    diff     = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_man = man_p1[i*manWidth +: manWidth];
      lane_lzc = lzc_p1[i*LZC_W +: LZC_W];
      diff     = signed'({1'b0, exp_p1}) - signed'(EW1'(lane_lzc));
      if (lane_man == '0)
        zero_nx[i] = 1'b1;
      else if (diff[expWidth] || (diff == '0))
        uflow_nx[i] = 1'b1;
      else begin
        exp_nx[i*expWidth +: expWidth] = diff[expWidth-1:0];
        man_nx[i*manWidth +: manWidth] = lane_man << lane_lzc;
      end
    end
  end

  // Stage 2: registered outputs, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_exp   <= '0;
      out_man   <= '0;
      out_zero  <= '0;
      out_uflow <= '0;
    end else if (s2_adv) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_exp   <= exp_nx;
        out_man   <= man_nx;
        out_zero  <= zero_nx;
        out_uflow <= uflow_nx;
      end
    end
  end

`ifdef BFP_UFLOW_CNT_EN
  function automatic logic [2:0] popcnt4(input logic [3:0] f);
    return 3'(f[0]) + 3'(f[1]) + 3'(f[2]) + 3'(f[3]);
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      uflow_cnt <= '0;
    else if (out_valid && out_ready)
      uflow_cnt <= sat_add16(uflow_cnt, popcnt4(out_uflow));
  end
`endif

endmodule
